// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath: widths, comp_en encodings,
// drain FSM states and saturation bounds.
package pe_pkg;

    localparam int unsigned PE_DATA_WIDTH   = 16;
    localparam int unsigned PE_ACT_NO_WIDTH = 6;
    localparam int unsigned PE_TRUNC_WIDTH  = 4;

    localparam int PE_SAT_MAX = 2 ** (PE_DATA_WIDTH - 1) - 1;
    localparam int PE_SAT_MIN = -(2 ** (PE_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        COMP_EN_IDLE = 2'd0,
        COMP_EN_W    = 2'd1,
        COMP_EN_U    = 2'd2,
        COMP_EN_V    = 2'd3
    } comp_en_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } pe_state_e;

endpackage

// File: rtl/pe_mult_trunc_sat.sv
// Combinational signed multiply, arithmetic right shift and saturation
// back to DATA_WIDTH.
module pe_mult_trunc_sat
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int unsigned TRUNC_WIDTH = PE_TRUNC_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]  act,
    input  logic [DATA_WIDTH-1:0]  weight,
    input  logic [TRUNC_WIDTH-1:0] trunc_amount,
    output logic [DATA_WIDTH-1:0]  result
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] MAX_EXT = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_EXT = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] act_ext;
    logic signed [PW-1:0] weight_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        act_ext    = {{DATA_WIDTH{act[DATA_WIDTH-1]}}, act};
        weight_ext = {{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight};
        prod       = act_ext * weight_ext;
        shifted    = prod >>> trunc_amount;
        if (shifted > MAX_EXT) begin
            result = MAX_EXT[DATA_WIDTH-1:0];
        end else if (shifted < MIN_EXT) begin
            result = MIN_EXT[DATA_WIDTH-1:0];
        end else begin
            result = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pe_mac_accum.sv
// Memory/execute stage: multiply-truncate-saturate, accumulate into a local
// output-activation register file, and drain it over valid/ready.
module pe_mac_accum
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = PE_DATA_WIDTH,
    parameter int unsigned ACT_NO_WIDTH = PE_ACT_NO_WIDTH,
    parameter int unsigned TRUNC_WIDTH  = PE_TRUNC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              comp_en_mem,
    input  logic [DATA_WIDTH-1:0]   in_act_value_mem,
    input  logic [ACT_NO_WIDTH-1:0] out_act_addr_mem,
    input  logic [TRUNC_WIDTH-1:0]  trunc_amount_mem,
    input  logic [DATA_WIDTH-1:0]   w_mem_q,
    input  logic [DATA_WIDTH-1:0]   u_mem_q,
    input  logic [DATA_WIDTH-1:0]   v_mem_q,
    input  logic                    drain_start,
    input  logic [ACT_NO_WIDTH:0]   drain_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACT_NO_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy,
    output logic                    err_overlap
);

    localparam int unsigned DEPTH = 2 ** ACT_NO_WIDTH;

    pe_state_e               state, state_nxt;
    logic [ACT_NO_WIDTH-1:0] cnt, cnt_nxt, last_idx;
    logic [DATA_WIDTH-1:0]   acc [DEPTH];

    comp_en_e                comp_en;
    logic [DATA_WIDTH-1:0]   weight;
    logic [DATA_WIDTH-1:0]   prod_sat;
    logic                    issue;
    logic                    overlap;
    logic                    drain_fire;

    logic                    x_valid;
    logic [ACT_NO_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0]   x_value;
    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH-1:0]   sum_sat;

    assign comp_en = comp_en_e'(comp_en_mem);
    assign issue   = (comp_en != COMP_EN_IDLE) && (state == ST_IDLE);
    assign overlap = (comp_en != COMP_EN_IDLE) && (state != ST_IDLE);

    always_comb begin
        weight = '0;
        case (comp_en)
            COMP_EN_W: weight = w_mem_q;
            COMP_EN_U: weight = u_mem_q;
            COMP_EN_V: weight = v_mem_q;
            default:   weight = '0;
        endcase
    end

    pe_mult_trunc_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TRUNC_WIDTH (TRUNC_WIDTH)
    ) u_mult_trunc_sat (
        .act          (in_act_value_mem),
        .weight       (weight),
        .trunc_amount (trunc_amount_mem),
        .result       (prod_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid <= 1'b0;
            x_addr  <= '0;
            x_value <= '0;
        end else begin
            x_valid <= issue;
            if (issue) begin
                x_addr  <= out_act_addr_mem;
                x_value <= prod_sat;
            end
        end
    end

    // Combinational read of the entry written last cycle gives RAW forwarding for free.
    always_comb begin
        sum_ext = {acc[x_addr][DATA_WIDTH-1], acc[x_addr]} + {x_value[DATA_WIDTH-1], x_value};
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            sum_sat = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum_sat = sum_ext[DATA_WIDTH-1:0];
        end
    end

    assign drain_fire = (state == ST_DRAIN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (x_valid) begin
                acc[x_addr] <= sum_sat;
            end
            if (drain_fire) begin
                acc[cnt] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_idx    <= '0;
            err_overlap <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // drain_count of zero wraps to the all-ones index, i.e. full depth.
            if (state == ST_IDLE && drain_start) begin
                last_idx <= ACT_NO_WIDTH'(drain_count - 1'b1);
            end
            if (overlap) begin
                err_overlap <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (drain_start) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_nxt = ST_DRAIN;
                cnt_nxt   = '0;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == last_idx) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign out_valid = (state == ST_DRAIN);
    assign out_addr  = out_valid ? cnt : '0;
    assign out_data  = out_valid ? acc[cnt] : '0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_pe_mac_accum.sv
// Scoreboard bench for pe_mac_accum: a reference accumulator model feeds an
// expected-output queue that is checked at every drained beat.
module tb_pe_mac_accum;
    import pe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  comp_en_mem;
    logic [15:0] in_act_value_mem;
    logic [5:0]  out_act_addr_mem;
    logic [3:0]  trunc_amount_mem;
    logic [15:0] w_mem_q, u_mem_q, v_mem_q;
    logic        drain_start;
    logic [6:0]  drain_count;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        err_overlap;

    pe_mac_accum #(
        .DATA_WIDTH   (16),
        .ACT_NO_WIDTH (6),
        .TRUNC_WIDTH  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .comp_en_mem      (comp_en_mem),
        .in_act_value_mem (in_act_value_mem),
        .out_act_addr_mem (out_act_addr_mem),
        .trunc_amount_mem (trunc_amount_mem),
        .w_mem_q          (w_mem_q),
        .u_mem_q          (u_mem_q),
        .v_mem_q          (v_mem_q),
        .drain_start      (drain_start),
        .drain_count      (drain_count),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .busy             (busy),
        .err_overlap      (err_overlap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m[64];
    int   n_vec    = 0;
    int   n_miscmp = 0;
    int   hs_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(input longint x);
        if (x > PE_SAT_MAX) return PE_SAT_MAX;
        if (x < PE_SAT_MIN) return PE_SAT_MIN;
        return int'(x);
    endfunction

    function automatic int mac_prod(input int act, input int wt, input int tr);
        longint p;
        p = longint'(act) * longint'(wt);
        p = p >>> tr;
        return clamp16(p);
    endfunction

    // Output monitor: every valid beat must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 32'd1, 32'd0);
            end else begin
                check_val("out_addr", {26'd0, out_addr}, {26'd0, exp_q[0].addr});
                check_val("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] ce, input int act, input int wt, input int tr, input int addr);
        comp_en_mem      = ce;
        in_act_value_mem = 16'(act);
        out_act_addr_mem = 6'(addr);
        trunc_amount_mem = 4'(tr);
        w_mem_q          = 16'($urandom);
        u_mem_q          = 16'($urandom);
        v_mem_q          = 16'($urandom);
        case (ce)
            COMP_EN_W: w_mem_q = 16'(wt);
            COMP_EN_U: u_mem_q = 16'(wt);
            COMP_EN_V: v_mem_q = 16'(wt);
            default: ;
        endcase
        if (ce != COMP_EN_IDLE)
            acc_m[addr] = clamp16(longint'(acc_m[addr]) + longint'(mac_prod(act, wt, tr)));
        @(posedge clk);
        #1;
        comp_en_mem = COMP_EN_IDLE;
    endtask

    task automatic push_drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr   = 6'(i);
            e.data   = 16'(acc_m[i]);
            acc_m[i] = 0;
            exp_q.push_back(e);
        end
    endtask

    // mode 1 toggles out_ready; ovl_at >= 0 issues a V op at that loop cycle.
    task automatic run_drain(input int count, input int mode, input int ovl_at, input bit started);
        int n;
        bit done;
        n      = (count == 0) ? 64 : count;
        done   = 1'b0;
        hs_cnt = 0;
        push_drain(n);
        drain_count = 7'(count);
        if (!started) begin
            drain_start = 1'b1;
            @(posedge clk);
            #1;
        end
        drain_start = 1'b0;
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            out_ready = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
            if (cyc == ovl_at) begin
                comp_en_mem      = COMP_EN_V;
                in_act_value_mem = 16'd7;
                v_mem_q          = 16'd7;
                out_act_addr_mem = 6'd1;
                trunc_amount_mem = 4'd0;
            end
            @(posedge clk);
            #1;
            comp_en_mem = COMP_EN_IDLE;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check_val("drain_done", {31'd0, done}, 32'd1);
        check_val("hs_count", 32'(hs_cnt), 32'(n));
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        comp_en_mem      = COMP_EN_IDLE;
        in_act_value_mem = '0;
        out_act_addr_mem = '0;
        trunc_amount_mem = '0;
        w_mem_q          = '0;
        u_mem_q          = '0;
        v_mem_q          = '0;
        drain_start      = 1'b0;
        drain_count      = '0;
        out_ready        = 1'b0;
        for (int i = 0; i < 64; i++) acc_m[i] = 0;

        #12;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {31'd0, err_overlap}, 32'd0);
        check_val("rst_out_addr", {26'd0, out_addr}, 32'd0);
        check_val("rst_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single W op, then drain six entries
        do_op(COMP_EN_W, 3, 4, 0, 5);
        run_drain(6, 0, -1, 1'b0);

        // back-to-back RAW, truncation and saturation cases
        do_op(COMP_EN_U, 1, 100, 0, 2);
        do_op(COMP_EN_U, 1, 100, 0, 2);
        do_op(COMP_EN_U, 1, 100, 0, 2);
        do_op(COMP_EN_W, 32767, 32767, 0, 10);
        do_op(COMP_EN_V, -256, 256, 8, 11);
        do_op(COMP_EN_W, 32767, 1, 0, 12);
        do_op(COMP_EN_U, 1, 1, 0, 12);
        do_op(COMP_EN_W, -32768, 32767, 0, 13);
        drain_start = 1'b1;
        drain_count = 7'd16;
        do_op(COMP_EN_V, -1, 1, 0, 13);
        run_drain(16, 1, -1, 1'b1);
        run_drain(16, 0, -1, 1'b0);

        // overlapping op during DRAIN is flagged and discarded
        do_op(COMP_EN_W, 2, 5, 0, 1);
        run_drain(4, 1, 3, 1'b0);
        check_val("err_set", {31'd0, err_overlap}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_val("err_sticky", {31'd0, err_overlap}, 32'd1);
        run_drain(4, 0, -1, 1'b0);
        check_val("err_still", {31'd0, err_overlap}, 32'd1);

        // async reset in the middle of a drain
        do_op(COMP_EN_W, 9, 9, 0, 0);
        do_op(COMP_EN_U, 1, -5, 0, 7);
        hs_cnt = 0;
        push_drain(8);
        drain_start = 1'b1;
        drain_count = 7'd8;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        for (int c = 0; c < 100 && hs_cnt < 3; c++) @(posedge clk);
        check_val("pre_reset_hs", 32'(hs_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_err", {31'd0, err_overlap}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) acc_m[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_drain(0, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
